lcd_ctrl: RTL



---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_cmd_fifo.sv | 61 ++++++
 rtl/lcd_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 command engine.
// The init ROM holds the power-up sequence: 8-bit/2-line, display on, clear, entry mode.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_IDLE,
      ST_SETUP,
      ST_EN_HI,
      ST_HOLD,
      ST_EXEC
   } lcd_state_t;

   localparam int CMD_W        = 9;
   localparam int CMD_RS_BIT   = 8;
   localparam int CMD_DATA_MSB = 7;

   localparam int INIT_LEN = 4;
   localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
   function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO for queued LCD commands; the head is readable
// combinationally so the FSM can latch it on the same edge it pops.
module lcd_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
)(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign full_o    = (r_count == (AW+1)'(DEPTH));
   assign empty_o   = (r_count == '0);
   assign count_o   = r_count;
   assign rd_data_o = r_mem[r_rd_ptr];
   assign w_push    = push_i && !full_o;
   assign w_pop     = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data_i;
      end
   end

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 command engine: power-up wait, init ROM replay, then queued LSU
// commands, each driven with setup / enable / hold / execution timing.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int T_PWRUP    = 750000,
   parameter int T_SETUP    = 2,
   parameter int T_EN       = 12,
   parameter int T_HOLD     = 1,
   parameter int T_EXEC     = 2000,
   parameter int T_CLEAR    = 76000
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   input  logic [CMD_W-1:0]  cmd_data_i,
   output logic              cmd_ready_o,
   output logic [7:0]        lcd_data_o,
   output logic              lcd_rs_o,
   output logic              lcd_rw_o,
   output logic              lcd_en_o,
   output logic              lcd_on_o,
   output logic              busy_o,
   output logic              init_done_o,
   output logic [31:0]       status_o
);

   localparam int T_MAX_A = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
   localparam int T_MAX_B = (T_EXEC > T_EN) ? T_EXEC : T_EN;
   localparam int T_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
   localparam int T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
   localparam int CNT_W   = $clog2(T_MAX) + 1;
   localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W   = $clog2(INIT_LEN) + 1;

   lcd_state_t        r_state;
   lcd_state_t        w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [7:0]        r_lcd_data;
   logic [7:0]        w_lcd_data_next;
   logic              r_lcd_rs;
   logic              w_lcd_rs_next;
   logic [PTR_W-1:0]  r_init_ptr;
   logic [PTR_W-1:0]  w_init_ptr_next;
   logic              r_init_done;
   logic              w_init_done_next;
   logic              r_lcd_en;
   logic              r_lcd_on;

   logic              w_push;
   logic              w_pop;
   logic [CMD_W-1:0]  w_fifo_head;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [FCNT_W-1:0] w_fifo_count;
   logic              w_cnt_zero;

   assign cmd_ready_o = !rst_i && !w_fifo_full;
   assign w_push      = cmd_valid_i && cmd_ready_o;
   assign w_cnt_zero  = (r_cnt == '0);

   lcd_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (w_push),
      .pop_i     (w_pop),
      .wr_data_i (cmd_data_i),
      .rd_data_o (w_fifo_head),
      .full_o    (w_fifo_full),
      .empty_o   (w_fifo_empty),
      .count_o   (w_fifo_count)
   );

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_lcd_data_next  = r_lcd_data;
      w_lcd_rs_next    = r_lcd_rs;
      w_init_ptr_next  = r_init_ptr;
      w_init_done_next = r_init_done;
      w_pop            = 1'b0;
      case (r_state)
         ST_PWRUP: begin
            if (w_cnt_zero) begin
               w_state_next    = ST_IDLE;
               w_init_ptr_next = '0;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_IDLE: begin
            if (!r_init_done) begin
               w_lcd_data_next = INIT_ROM[r_init_ptr[PTR_W-2:0]];
               w_lcd_rs_next   = 1'b0;
               w_init_ptr_next = r_init_ptr + 1'b1;
               w_cnt_next      = CNT_W'(T_SETUP - 1);
               w_state_next    = ST_SETUP;
            end else if (!w_fifo_empty) begin
               w_pop           = 1'b1;
               w_lcd_data_next = w_fifo_head[CMD_DATA_MSB:0];
               w_lcd_rs_next   = w_fifo_head[CMD_RS_BIT];
               w_cnt_next      = CNT_W'(T_SETUP - 1);
               w_state_next    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (w_cnt_zero) begin
               w_cnt_next   = CNT_W'(T_EN - 1);
               w_state_next = ST_EN_HI;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_EN_HI: begin
            if (w_cnt_zero) begin
               w_cnt_next   = CNT_W'(T_HOLD - 1);
               w_state_next = ST_HOLD;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_HOLD: begin
            if (w_cnt_zero) begin
               w_cnt_next   = is_slow_cmd(r_lcd_rs, r_lcd_data) ? CNT_W'(T_CLEAR - 1)
                                                                 : CNT_W'(T_EXEC - 1);
               w_state_next = ST_EXEC;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_EXEC: begin
            if (w_cnt_zero) begin
               w_state_next = ST_IDLE;
               // The pointer has already moved past the last ROM entry here.
               if (!r_init_done && (r_init_ptr == PTR_W'(INIT_LEN))) begin
                  w_init_done_next = 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_next = ST_PWRUP;
            w_cnt_next   = CNT_W'(T_PWRUP - 1);
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_PWRUP;
         r_cnt       <= CNT_W'(T_PWRUP - 1);
         r_lcd_data  <= '0;
         r_lcd_rs    <= 1'b0;
         r_init_ptr  <= '0;
         r_init_done <= 1'b0;
         r_lcd_en    <= 1'b0;
         r_lcd_on    <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_lcd_data  <= w_lcd_data_next;
         r_lcd_rs    <= w_lcd_rs_next;
         r_init_ptr  <= w_init_ptr_next;
         r_init_done <= w_init_done_next;
         r_lcd_en    <= (w_state_next == ST_EN_HI);
         r_lcd_on    <= 1'b1;
      end
   end

   assign lcd_data_o  = r_lcd_data;
   assign lcd_rs_o    = r_lcd_rs;
   assign lcd_rw_o    = 1'b0;
   assign lcd_en_o    = r_lcd_en;
   assign lcd_on_o    = r_lcd_on;
   assign init_done_o = r_init_done;
   assign busy_o      = (r_state != ST_IDLE) || !r_init_done || (w_fifo_count != '0);
   assign status_o    = {30'b0, init_done_o, busy_o};

endmodule
